// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin synchronisation, clock glitch filter, 11-bit
// frame deframing with parity/stop/timeout checks, optional E0/F0 prefix
// folding, and an event FIFO read by the CPU-side keyboard logic.
module ps2_keyboard_rx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT    = 10000,
    parameter bit          DECODE     = 1'b1
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          nextdata_n,
    input  logic                          err_clr,
    output logic [9:0]                    data,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          parity_err,
    output logic                          frame_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          ps2c_s;
    logic          ps2d_s;
    logic          fclk;
    logic          fclk_d;
    logic [FW-1:0] flt_cnt;
    logic          strobe;

    state_t        state;
    state_t        state_n;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_ok;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          byte_valid;
    logic          perr_evt;
    logic          ferr_evt;

    logic          ext_pend;
    logic          brk_pend;
    logic          push;
    logic [9:0]    push_data;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          ovf_evt;

    assign ps2c_s = clk_sync[1];
    assign ps2d_s = dat_sync[1];

    // Two-flop synchronisers for both pins, idling high like the bus.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // Accept a new ps2_clk level only after it persists FILTER_LEN cycles.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fclk    <= 1'b1;
            fclk_d  <= 1'b1;
            flt_cnt <= '0;
        end else begin
            fclk_d <= fclk;
            if (ps2c_s == fclk) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                fclk    <= ps2c_s;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign strobe = fclk_d & ~fclk;

    // Frame state register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and per-frame result events; timeout outranks a strobe-less cycle.
    always_comb begin
        state_n    = state;
        byte_valid = 1'b0;
        perr_evt   = 1'b0;
        ferr_evt   = 1'b0;
        tmo_hit    = 1'b0;
        if ((state != S_IDLE) && !strobe && (tmo_cnt == TW'(TIMEOUT - 1))) begin
            tmo_hit  = 1'b1;
            ferr_evt = 1'b1;
            state_n  = S_IDLE;
        end else if (strobe) begin
            case (state)
                S_IDLE:   if (!ps2d_s) state_n = S_DATA;
                S_DATA:   if (bit_idx == 3'd7) state_n = S_PARITY;
                S_PARITY: state_n = S_STOP;
                S_STOP: begin
                    state_n = S_IDLE;
                    if (!ps2d_s) begin
                        ferr_evt = 1'b1;
                    end else if (!par_ok) begin
                        perr_evt = 1'b1;
                    end else begin
                        byte_valid = 1'b1;
                    end
                end
                default:  state_n = S_IDLE;
            endcase
        end
    end

    // Frame datapath: LSB-first shift, parity latch and mid-frame timeout counter.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_idx <= '0;
            shreg   <= '0;
            par_ok  <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            if (strobe) begin
                case (state)
                    S_IDLE:   bit_idx <= '0;
                    S_DATA: begin
                        shreg   <= {ps2d_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                    S_PARITY: par_ok <= ^{shreg, ps2d_s};
                    default:  ;
                endcase
            end
            if ((state == S_IDLE) || strobe || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    // Turn a completed byte into a FIFO event, folding prefixes when enabled.
    always_comb begin
        push      = 1'b0;
        push_data = {2'b00, shreg};
        if (byte_valid) begin
            if (DECODE) begin
                push_data = {ext_pend, brk_pend, shreg};
                push      = (shreg != 8'hE0) && (shreg != 8'hF0);
            end else begin
                push = 1'b1;
            end
        end
    end

    // Prefix flags: set by E0/F0, cleared by any other byte or any bad frame.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (perr_evt || ferr_evt) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (byte_valid && DECODE) begin
            if (shreg == 8'hE0) begin
                ext_pend <= 1'b1;
            end else if (shreg == 8'hF0) begin
                brk_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    assign ready   = (count != '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop     = !nextdata_n && ready;
    assign wr_en   = push && (!full || pop);
    assign ovf_evt = push && !wr_en;
    // Gated so the head reads 0 when empty, including during reset.
    assign data    = ready ? mem[rptr] : '0;

    // Event storage; contents need no reset since reads are gated by ready.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= push_data;
        end
    end

    // FIFO pointers and explicit occupancy count.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (pop)   rptr <= rptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a same-cycle set beats err_clr.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (ovf_evt)       overflow <= 1'b1;
            else if (err_clr)  overflow <= 1'b0;
            if (perr_evt)      parity_err <= 1'b1;
            else if (err_clr)  parity_err <= 1'b0;
            if (ferr_evt)      frame_err <= 1'b1;
            else if (err_clr)  frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: a decoding 4-deep instance (a_*) and a
// raw 8-deep instance (b_*) share the PS/2 pins, reset and err_clr.
module tb_ps2_keyboard_rx;

    logic       clk;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       err_clr;
    logic       nd_a;
    logic       nd_b;

    logic [9:0] a_data;
    logic       a_ready;
    logic [2:0] a_count;
    logic       a_ovf;
    logic       a_perr;
    logic       a_ferr;

    logic [9:0] b_data;
    logic       b_ready;
    logic [3:0] b_count;
    logic       b_ovf;
    logic       b_perr;
    logic       b_ferr;

    int unsigned n_cmp;
    int unsigned n_bad;

    ps2_keyboard_rx #(
        .FIFO_DEPTH(4), .FILTER_LEN(4), .TIMEOUT(100), .DECODE(1'b1)
    ) u_dut_a (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nd_a), .err_clr(err_clr), .data(a_data), .ready(a_ready),
        .count(a_count), .overflow(a_ovf), .parity_err(a_perr), .frame_err(a_ferr)
    );

    ps2_keyboard_rx #(
        .FIFO_DEPTH(8), .FILTER_LEN(4), .TIMEOUT(100), .DECODE(1'b0)
    ) u_dut_b (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nd_b), .err_clr(err_clr), .data(b_data), .ready(b_ready),
        .count(b_count), .overflow(b_ovf), .parity_err(b_perr), .frame_err(b_ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  code;
        bit          clr;
        bit          bad_par;
        bit          bad_stop;
        int unsigned a_cnt;
        logic [9:0]  a_head;
        int unsigned b_cnt;
        logic        perr;
        logic        ferr;
        bit          drain;
    } vec_t;

    vec_t tbl1[7];
    vec_t tbl2[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Device-side frame: data changes while clock high, host samples on fall.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int unsigned nbits, input bit glitch, input bit pop_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int unsigned i = 0; i < nbits; i++) begin
            ps2_data = bits[0];
            bits     = bits >> 1;
            repeat (10) @(negedge clk);
            ps2_clk = 1'b0;
            if (pop_stop && i == 10) begin
                repeat (6) @(posedge clk);
                #1 nd_a = 1'b0;
                @(posedge clk);
                #1 nd_a = 1'b1;
                repeat (12) @(negedge clk);
            end else begin
                repeat (20) @(negedge clk);
            end
            ps2_clk = 1'b1;
            if (glitch && i == 3) begin
                repeat (8) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (2) @(negedge clk);
                ps2_clk = 1'b1;
            end
            repeat (10) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic pop_a(input logic [9:0] exp, input string nm);
        check(nm, a_data, exp);
        nd_a = 1'b0;
        @(negedge clk);
        nd_a = 1'b1;
    endtask

    task automatic pop_b(input logic [9:0] exp, input string nm);
        check(nm, b_data, exp);
        nd_b = 1'b0;
        @(negedge clk);
        nd_b = 1'b1;
    endtask

    task automatic drain_all();
        nd_a = 1'b0;
        nd_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!a_ready && !b_ready) break;
            @(negedge clk);
        end
        nd_a = 1'b1;
        nd_b = 1'b1;
        check("drain_a_count", a_count, 0);
        check("drain_b_count", b_count, 0);
    endtask

    task automatic apply(input vec_t v, input int unsigned idx);
        if (v.clr) pulse_clr();
        send_frame(v.code, v.bad_par, v.bad_stop, 11, 1'b0, 1'b0);
        check($sformatf("v%0d_a_count", idx), a_count, v.a_cnt);
        if (v.a_cnt != 0) check($sformatf("v%0d_a_data", idx), a_data, v.a_head);
        check($sformatf("v%0d_b_count", idx), b_count, v.b_cnt);
        check($sformatf("v%0d_perr", idx), a_perr, v.perr);
        check($sformatf("v%0d_ferr", idx), a_ferr, v.ferr);
        if (v.drain) drain_all();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] codes[5];
        n_cmp    = 0;
        n_bad    = 0;
        clrn     = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        err_clr  = 1'b0;
        nd_a     = 1'b1;
        nd_b     = 1'b1;

        //            code   clr bp bs acnt head      bcnt perr ferr drain
        tbl1[0] = '{8'h1C, 0, 0, 0, 1, 10'h01C, 1, 1'b0, 1'b0, 1};
        tbl1[1] = '{8'hE0, 0, 0, 0, 0, 10'h000, 1, 1'b0, 1'b0, 0};
        tbl1[2] = '{8'hF0, 0, 0, 0, 0, 10'h000, 2, 1'b0, 1'b0, 0};
        tbl1[3] = '{8'h75, 0, 0, 0, 1, 10'h375, 3, 1'b0, 1'b0, 0};
        tbl1[4] = '{8'hF0, 0, 0, 0, 1, 10'h375, 4, 1'b0, 1'b0, 0};
        tbl1[5] = '{8'h1C, 0, 0, 0, 2, 10'h375, 5, 1'b0, 1'b0, 0};
        tbl1[6] = '{8'h1C, 0, 0, 0, 3, 10'h375, 6, 1'b0, 1'b0, 0};

        tbl2[0] = '{8'hE0, 0, 0, 0, 0, 10'h000, 1, 1'b0, 1'b0, 1};
        tbl2[1] = '{8'h1C, 0, 1, 0, 0, 10'h000, 0, 1'b1, 1'b0, 0};
        tbl2[2] = '{8'h1C, 0, 0, 1, 0, 10'h000, 0, 1'b1, 1'b1, 0};
        tbl2[3] = '{8'h1C, 1, 0, 0, 1, 10'h01C, 1, 1'b0, 1'b0, 1};
        tbl2[4] = '{8'h1C, 0, 1, 1, 0, 10'h000, 0, 1'b0, 1'b1, 0};
        tbl2[5] = '{8'h23, 1, 0, 0, 1, 10'h023, 1, 1'b0, 1'b0, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", a_data, 10'h000);
        check("rst_ready", a_ready, 1'b0);
        check("rst_count", a_count, 0);
        check("rst_ovf", a_ovf, 1'b0);
        check("rst_perr", a_perr, 1'b0);
        check("rst_ferr", a_ferr, 1'b0);
        clrn = 1'b1;
        repeat (10) @(negedge clk);

        // Pop on empty is ignored
        nd_a = 1'b0;
        @(negedge clk);
        nd_a = 1'b1;
        check("empty_pop_count", a_count, 0);
        check("empty_pop_ready", a_ready, 1'b0);

        // Decoder folding vs raw bytes
        for (int unsigned i = 0; i < 7; i++) apply(tbl1[i], i);
        pop_a(10'h375, "a_pop0");
        pop_a(10'h11C, "a_pop1");
        pop_a(10'h01C, "a_pop2");
        check("a_after_pops", a_count, 0);
        pop_b(10'h0E0, "b_pop0");
        pop_b(10'h0F0, "b_pop1");
        pop_b(10'h075, "b_pop2");
        pop_b(10'h0F0, "b_pop3");
        pop_b(10'h01C, "b_pop4");
        pop_b(10'h01C, "b_pop5");
        check("b_after_pops", b_count, 0);

        // Parity/stop errors, priority, err_clr, pend clearing on error
        for (int unsigned i = 0; i < 6; i++) apply(tbl2[i], 10 + i);

        // Timeout after 4 data bits
        send_frame(8'hFF, 1'b0, 1'b0, 5, 1'b0, 1'b0);
        repeat (110) @(negedge clk);
        check("tmo_ferr", a_ferr, 1'b1);
        check("tmo_perr", a_perr, 1'b0);
        check("tmo_count", a_count, 0);
        pulse_clr();
        send_frame(8'h23, 1'b0, 1'b0, 11, 1'b0, 1'b0);
        check("tmo_next_data", a_data, 10'h023);
        check("tmo_next_count", a_count, 1);
        check("tmo_next_ferr", a_ferr, 1'b0);
        drain_all();

        // Overflow on the 4-deep FIFO
        codes[0] = 8'h11; codes[1] = 8'h22; codes[2] = 8'h33; codes[3] = 8'h44; codes[4] = 8'h55;
        for (int unsigned i = 0; i < 5; i++) send_frame(codes[i], 1'b0, 1'b0, 11, 1'b0, 1'b0);
        check("ovf_count", a_count, 4);
        check("ovf_flag", a_ovf, 1'b1);
        check("ovf_b_count", b_count, 5);
        check("ovf_b_flag", b_ovf, 1'b0);
        pop_a(10'h011, "ovf_pop0");
        pop_a(10'h022, "ovf_pop1");
        pop_a(10'h033, "ovf_pop2");
        pop_a(10'h044, "ovf_pop3");
        check("ovf_empty", a_ready, 1'b0);
        drain_all();
        pulse_clr();
        check("ovf_cleared", a_ovf, 1'b0);

        // Push coinciding with pop while full
        codes[0] = 8'h66; codes[1] = 8'h77; codes[2] = 8'h88; codes[3] = 8'h99;
        for (int unsigned i = 0; i < 4; i++) send_frame(codes[i], 1'b0, 1'b0, 11, 1'b0, 1'b0);
        check("full_count", a_count, 4);
        send_frame(8'hAA, 1'b0, 1'b0, 11, 1'b0, 1'b1);
        check("pushpop_count", a_count, 4);
        check("pushpop_ovf", a_ovf, 1'b0);
        pop_a(10'h077, "pushpop_pop0");
        pop_a(10'h088, "pushpop_pop1");
        pop_a(10'h099, "pushpop_pop2");
        pop_a(10'h0AA, "pushpop_pop3");
        drain_all();

        // Glitch on ps2_clk mid-frame must not add a bit
        send_frame(8'h5A, 1'b0, 1'b0, 11, 1'b1, 1'b0);
        check("glitch_data", a_data, 10'h05A);
        check("glitch_count", a_count, 1);
        check("glitch_perr", a_perr, 1'b0);
        check("glitch_ferr", a_ferr, 1'b0);

        // Reset mid-frame with a queued entry and a raised flag
        send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0, 1'b0);
        check("pre_rst_perr", a_perr, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0, 4, 1'b0, 1'b0);
        clrn = 1'b0;
        #1;
        check("mid_rst_data", a_data, 10'h000);
        check("mid_rst_ready", a_ready, 1'b0);
        check("mid_rst_count", a_count, 0);
        check("mid_rst_perr", a_perr, 1'b0);
        check("mid_rst_ferr", a_ferr, 1'b0);
        check("mid_rst_b_ready", b_ready, 1'b0);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (150) @(negedge clk);
        check("post_rst_ferr", a_ferr, 1'b0);
        check("post_rst_ready", a_ready, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 11, 1'b0, 1'b0);
        check("post_rst_data", a_data, 10'h03C);
        check("post_rst_count", a_count, 1);
        check("post_rst_perr", a_perr, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
